// File: rtl/rob_complete_pkg.sv
// Shared types and constants for the reorder buffer / retire stage.
package rob_complete_pkg;

   localparam int ROB_DEPTH = 16;
   localparam int PREGW     = 6;
   localparam int DATAW     = 32;
   localparam int OPW       = 7;

   // Opcodes that retire without producing a register result.
   localparam logic [OPW-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPW-1:0] OP_BRANCH = 7'b1100011;

   // One reorder-buffer row.
   typedef struct packed {
      logic             valid;
      logic             done;
      logic [PREGW-1:0] pd;
      logic [OPW-1:0]   op;
      logic [PREGW-1:0] opd;
      logic [DATAW-1:0] data;
   } rob_entry_t;

   // True when retiring this opcode writes the PRF and frees the old mapping.
   function automatic logic writes_reg(input logic [OPW-1:0] op);
      return (op != OP_STORE) && (op != OP_BRANCH);
   endfunction

endpackage

// File: rtl/rob_complete_retire_select.sv
// Picks up to two in-order retirements starting at head.
// Slot 2 may only retire when slot 1 does, so retirement never skips an entry.
module rob_retire_select
   import rob_complete_pkg::*;
#(
   parameter  int DEPTH = ROB_DEPTH,
   localparam int IDXW  = $clog2(DEPTH)
) (
   input  logic [IDXW-1:0]  head,
   input  logic [DEPTH-1:0] valid,
   input  logic [DEPTH-1:0] done,
   output logic [1:0]       retire_cnt,
   output logic [IDXW-1:0]  retire_idx_1,
   output logic [IDXW-1:0]  retire_idx_2
);

   logic ok_1;
   logic ok_2;

   // Evaluate the two oldest entries and count how many are ready to leave.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      retire_idx_1 = head;
      retire_idx_2 = head + IDXW'(1);
      ok_1         = 1'b0;
      ok_2         = 1'b0;
      ok_1         = valid[retire_idx_1] && done[retire_idx_1];
      ok_2         = ok_1 && valid[retire_idx_2] && done[retire_idx_2];
      retire_cnt   = 2'(ok_1) + 2'(ok_2);
   end

endmodule

// File: rtl/rob_complete.sv
// Reorder buffer with completion, result forwarding and two-wide in-order retire.
// Dispatch allocates entries in pairs; FU results mark entries done; the two
// oldest done entries retire per cycle, writing the PRF and freeing old pregs.
module rob_complete
   import rob_complete_pkg::*;
#(
   parameter  int DEPTH = ROB_DEPTH,
   localparam int IDXW  = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   // allocation from dispatch
   input  logic             u_rob,
   input  logic [PREGW-1:0] rob_p_1,
   input  logic [PREGW-1:0] rob_p_2,
   input  logic [OPW-1:0]   rob_op_1,
   input  logic [OPW-1:0]   rob_op_2,
   input  logic [PREGW-1:0] o_rob_p_1,
   input  logic [PREGW-1:0] o_rob_p_2,
   output logic             alloc_ready,
   output logic [IDXW-1:0]  alloc_idx_1,
   output logic [IDXW-1:0]  alloc_idx_2,
   // functional-unit results
   input  logic             result_valid_1,
   input  logic             result_valid_2,
   input  logic             result_valid_3,
   input  logic [IDXW-1:0]  result_ROB_1,
   input  logic [IDXW-1:0]  result_ROB_2,
   input  logic [IDXW-1:0]  result_ROB_3,
   input  logic [PREGW-1:0] result_dest_1,
   input  logic [PREGW-1:0] result_dest_2,
   input  logic [PREGW-1:0] result_dest_3,
   input  logic [DATAW-1:0] result_1,
   input  logic [DATAW-1:0] result_2,
   input  logic [DATAW-1:0] result_3,
   // forwarding back to dispatch
   output logic             f_flag_1,
   output logic             f_flag_2,
   output logic             f_flag_3,
   output logic [PREGW-1:0] dest_r_1,
   output logic [PREGW-1:0] dest_r_2,
   output logic [PREGW-1:0] dest_r_3,
   output logic [DATAW-1:0] f_data_1,
   output logic [DATAW-1:0] f_data_2,
   output logic [DATAW-1:0] f_data_3,
   // retirement
   output logic             prf_we_1,
   output logic             prf_we_2,
   output logic [PREGW-1:0] prf_addr_1,
   output logic [PREGW-1:0] prf_addr_2,
   output logic [DATAW-1:0] prf_data_1,
   output logic [DATAW-1:0] prf_data_2,
   output logic             free_valid_1,
   output logic             free_valid_2,
   output logic [PREGW-1:0] free_preg_1,
   output logic [PREGW-1:0] free_preg_2,
   output logic [IDXW:0]    rob_count
);

   localparam int CNTW  = IDXW + 1;
   localparam int NPORT = 3;

   rob_entry_t       rob [DEPTH];
   logic [IDXW-1:0]  head;
   logic [IDXW-1:0]  tail;
   logic [CNTW-1:0]  count;
   logic [CNTW-1:0]  count_next;
   logic             alloc_accept;

   logic [DEPTH-1:0] valid_vec;
   logic [DEPTH-1:0] done_vec;
   logic [1:0]       retire_cnt;
   logic [IDXW-1:0]  retire_idx_1;
   logic [IDXW-1:0]  retire_idx_2;

   // Result ports gathered into arrays so completion and forwarding can loop.
   logic             res_valid [NPORT];
   logic [IDXW-1:0]  res_idx   [NPORT];
   logic [PREGW-1:0] res_dest  [NPORT];
   logic [DATAW-1:0] res_data  [NPORT];

   logic             fwd_flag  [NPORT];
   logic [PREGW-1:0] fwd_dest  [NPORT];
   logic [DATAW-1:0] fwd_data  [NPORT];

   assign res_valid[0] = result_valid_1;
   assign res_valid[1] = result_valid_2;
   assign res_valid[2] = result_valid_3;
   assign res_idx[0]   = result_ROB_1;
   assign res_idx[1]   = result_ROB_2;
   assign res_idx[2]   = result_ROB_3;
   assign res_dest[0]  = result_dest_1;
   assign res_dest[1]  = result_dest_2;
   assign res_dest[2]  = result_dest_3;
   assign res_data[0]  = result_1;
   assign res_data[1]  = result_2;
   assign res_data[2]  = result_3;

   assign f_flag_1 = fwd_flag[0];
   assign f_flag_2 = fwd_flag[1];
   assign f_flag_3 = fwd_flag[2];
   assign dest_r_1 = fwd_dest[0];
   assign dest_r_2 = fwd_dest[1];
   assign dest_r_3 = fwd_dest[2];
   assign f_data_1 = fwd_data[0];
   assign f_data_2 = fwd_data[1];
   assign f_data_3 = fwd_data[2];

   // Space check uses registered count only, so it never depends on this cycle's retire.
   assign alloc_ready  = (count <= CNTW'(DEPTH - 2));
   assign alloc_accept = u_rob && alloc_ready;
   assign alloc_idx_1  = tail;
   assign alloc_idx_2  = tail + IDXW'(1);
   assign rob_count    = count;

   // Flatten entry status bits for the retire selector.
   always_comb begin
      valid_vec = '0;
      done_vec  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         valid_vec[i] = rob[i].valid;
         done_vec[i]  = rob[i].done;
      end
   end

   rob_retire_select #(.DEPTH(DEPTH)) u_retire_select (
      .head         (head),
      .valid        (valid_vec),
      .done         (done_vec),
      .retire_cnt   (retire_cnt),
      .retire_idx_1 (retire_idx_1),
      .retire_idx_2 (retire_idx_2)
   );

   // Occupancy after this cycle's allocation and retirement.
   always_comb begin
      count_next = count + (alloc_accept ? CNTW'(2) : CNTW'(0)) - CNTW'(retire_cnt);
   end

   // Entry array: completion, then retire clear, then allocation (later writes win).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the entry array is reset on purpose; stale valid bits after reset would retire garbage.
         for (int i = 0; i < DEPTH; i++) begin
            rob[i] <= '0;
         end
      end else begin
         // Highest-numbered port is written first so port 1 has the final say on a collision.
         for (int p = NPORT - 1; p >= 0; p--) begin
            if (res_valid[p] && rob[res_idx[p]].valid) begin
               rob[res_idx[p]].done <= 1'b1;
               rob[res_idx[p]].data <= res_data[p];
            end
         end
         if (retire_cnt != 2'd0) begin
            rob[retire_idx_1] <= '0;
         end
         if (retire_cnt == 2'd2) begin
            rob[retire_idx_2] <= '0;
         end
         // Tail entries are invalid here (alloc needs two free slots), so no completion overlaps.
         if (alloc_accept) begin
            rob[alloc_idx_1] <= '{valid: 1'b1, done: 1'b0, pd: rob_p_1, op: rob_op_1,
                                  opd: o_rob_p_1, data: '0};
            rob[alloc_idx_2] <= '{valid: 1'b1, done: 1'b0, pd: rob_p_2, op: rob_op_2,
                                  opd: o_rob_p_2, data: '0};
         end
      end
   end

   // Head, tail and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every block sees pre-edge values.
         head  <= head + IDXW'(retire_cnt);
         tail  <= tail + (alloc_accept ? IDXW'(2) : IDXW'(0));
         count <= count_next;
      end
   end

   // Forward each FU result to dispatch one cycle later; payload holds when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < NPORT; p++) begin
            fwd_flag[p] <= 1'b0;
            fwd_dest[p] <= '0;
            fwd_data[p] <= '0;
         end
      end else begin
         for (int p = 0; p < NPORT; p++) begin
            fwd_flag[p] <= res_valid[p];
            if (res_valid[p]) begin
               fwd_dest[p] <= res_dest[p];
               fwd_data[p] <= res_data[p];
            end
         end
      end
   end

   // Registered retire outputs: PRF write and old-preg release per slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prf_we_1     <= 1'b0;
         prf_we_2     <= 1'b0;
         prf_addr_1   <= '0;
         prf_addr_2   <= '0;
         prf_data_1   <= '0;
         prf_data_2   <= '0;
         free_valid_1 <= 1'b0;
         free_valid_2 <= 1'b0;
         free_preg_1  <= '0;
         free_preg_2  <= '0;
      end else begin
         prf_we_1     <= (retire_cnt != 2'd0) && writes_reg(rob[retire_idx_1].op);
         free_valid_1 <= (retire_cnt != 2'd0) && writes_reg(rob[retire_idx_1].op);
         prf_we_2     <= (retire_cnt == 2'd2) && writes_reg(rob[retire_idx_2].op);
         free_valid_2 <= (retire_cnt == 2'd2) && writes_reg(rob[retire_idx_2].op);
         if (retire_cnt != 2'd0) begin
            prf_addr_1  <= rob[retire_idx_1].pd;
            prf_data_1  <= rob[retire_idx_1].data;
            free_preg_1 <= rob[retire_idx_1].opd;
         end
         if (retire_cnt == 2'd2) begin
            prf_addr_2  <= rob[retire_idx_2].pd;
            prf_data_2  <= rob[retire_idx_2].data;
            free_preg_2 <= rob[retire_idx_2].opd;
         end
      end
   end

endmodule

// File: tb/tb_rob_complete.sv
// Self-checking bench for rob_complete: directed scenarios plus random traffic,
// compared against a program-order queue model of the reorder buffer.
module tb_rob_complete;

   localparam logic [6:0] T_STORE  = 7'b0100011;
   localparam logic [6:0] T_BRANCH = 7'b1100011;
   localparam logic [6:0] T_ALU    = 7'b0110011;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        u_rob;
   logic [5:0]  rob_p   [2];
   logic [6:0]  rob_op  [2];
   logic [5:0]  o_rob_p [2];
   logic        rv      [3];
   logic [3:0]  rrob    [3];
   logic [5:0]  rdest   [3];
   logic [31:0] rdata   [3];

   logic        alloc_ready;
   logic [3:0]  alloc_idx_1, alloc_idx_2;
   logic        f_flag_1, f_flag_2, f_flag_3;
   logic [5:0]  dest_r_1, dest_r_2, dest_r_3;
   logic [31:0] f_data_1, f_data_2, f_data_3;
   logic        prf_we_1, prf_we_2;
   logic [5:0]  prf_addr_1, prf_addr_2;
   logic [31:0] prf_data_1, prf_data_2;
   logic        free_valid_1, free_valid_2;
   logic [5:0]  free_preg_1, free_preg_2;
   logic [4:0]  rob_count;

   always #5 clk = ~clk;

   rob_complete dut (
      .clk(clk), .rst(rst), .u_rob(u_rob),
      .rob_p_1(rob_p[0]), .rob_p_2(rob_p[1]),
      .rob_op_1(rob_op[0]), .rob_op_2(rob_op[1]),
      .o_rob_p_1(o_rob_p[0]), .o_rob_p_2(o_rob_p[1]),
      .alloc_ready(alloc_ready), .alloc_idx_1(alloc_idx_1), .alloc_idx_2(alloc_idx_2),
      .result_valid_1(rv[0]), .result_valid_2(rv[1]), .result_valid_3(rv[2]),
      .result_ROB_1(rrob[0]), .result_ROB_2(rrob[1]), .result_ROB_3(rrob[2]),
      .result_dest_1(rdest[0]), .result_dest_2(rdest[1]), .result_dest_3(rdest[2]),
      .result_1(rdata[0]), .result_2(rdata[1]), .result_3(rdata[2]),
      .f_flag_1(f_flag_1), .f_flag_2(f_flag_2), .f_flag_3(f_flag_3),
      .dest_r_1(dest_r_1), .dest_r_2(dest_r_2), .dest_r_3(dest_r_3),
      .f_data_1(f_data_1), .f_data_2(f_data_2), .f_data_3(f_data_3),
      .prf_we_1(prf_we_1), .prf_we_2(prf_we_2),
      .prf_addr_1(prf_addr_1), .prf_addr_2(prf_addr_2),
      .prf_data_1(prf_data_1), .prf_data_2(prf_data_2),
      .free_valid_1(free_valid_1), .free_valid_2(free_valid_2),
      .free_preg_1(free_preg_1), .free_preg_2(free_preg_2),
      .rob_count(rob_count)
   );

   // Reference model: outstanding instructions in program order.
   typedef struct {
      int          idx;
      logic [5:0]  pd;
      logic [6:0]  op;
      logic [5:0]  opd;
      bit          done;
      logic [31:0] data;
   } mentry_t;

   mentry_t     mq[$];
   int          m_tail;
   logic        e_ff [3];
   logic [5:0]  e_dr [3];
   logic [31:0] e_fd [3];
   logic        e_we [2];
   logic [5:0]  e_pa [2];
   logic [31:0] e_pd [2];
   logic [5:0]  e_fp [2];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit has_result(input logic [6:0] op);
      return !(op == T_STORE || op == T_BRANCH);
   endfunction

   task automatic check_all(input string tag);
      check({tag, ":f_flag_1"}, f_flag_1, e_ff[0]);
      check({tag, ":f_flag_2"}, f_flag_2, e_ff[1]);
      check({tag, ":f_flag_3"}, f_flag_3, e_ff[2]);
      check({tag, ":dest_r_1"}, dest_r_1, e_dr[0]);
      check({tag, ":dest_r_2"}, dest_r_2, e_dr[1]);
      check({tag, ":dest_r_3"}, dest_r_3, e_dr[2]);
      check({tag, ":f_data_1"}, f_data_1, e_fd[0]);
      check({tag, ":f_data_2"}, f_data_2, e_fd[1]);
      check({tag, ":f_data_3"}, f_data_3, e_fd[2]);
      check({tag, ":prf_we_1"}, prf_we_1, e_we[0]);
      check({tag, ":prf_we_2"}, prf_we_2, e_we[1]);
      check({tag, ":free_valid_1"}, free_valid_1, e_we[0]);
      check({tag, ":free_valid_2"}, free_valid_2, e_we[1]);
      check({tag, ":prf_addr_1"}, prf_addr_1, e_pa[0]);
      check({tag, ":prf_addr_2"}, prf_addr_2, e_pa[1]);
      check({tag, ":prf_data_1"}, prf_data_1, e_pd[0]);
      check({tag, ":prf_data_2"}, prf_data_2, e_pd[1]);
      check({tag, ":free_preg_1"}, free_preg_1, e_fp[0]);
      check({tag, ":free_preg_2"}, free_preg_2, e_fp[1]);
      check({tag, ":rob_count"}, rob_count, mq.size());
      check({tag, ":alloc_ready"}, alloc_ready, (mq.size() <= 14) ? 1 : 0);
      check({tag, ":alloc_idx_1"}, alloc_idx_1, m_tail % 16);
      check({tag, ":alloc_idx_2"}, alloc_idx_2, (m_tail + 1) % 16);
   endtask

   task automatic clear_inputs();
      u_rob = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rob_p[i] = '0; rob_op[i] = '0; o_rob_p[i] = '0;
      end
      for (int p = 0; p < 3; p++) begin
         rv[p] = 1'b0; rrob[p] = '0; rdest[p] = '0; rdata[p] = '0;
      end
   endtask

   task automatic set_alloc(input logic [5:0] pd1, input logic [6:0] op1, input logic [5:0] opd1,
                            input logic [5:0] pd2, input logic [6:0] op2, input logic [5:0] opd2);
      u_rob = 1'b1;
      rob_p[0] = pd1; rob_op[0] = op1; o_rob_p[0] = opd1;
      rob_p[1] = pd2; rob_op[1] = op2; o_rob_p[1] = opd2;
   endtask

   task automatic set_res(input int p, input int idx, input logic [5:0] dest, input logic [31:0] d);
      rv[p] = 1'b1; rrob[p] = 4'(idx); rdest[p] = dest; rdata[p] = d;
   endtask

   // One clock: advance the model from the driven inputs, clock the DUT, compare.
   task automatic tick(input string tag = "tick");
      int n;
      int cnt0;
      bit won [16];
      cnt0 = mq.size();
      foreach (won[i]) won[i] = 1'b0;
      // retirement looks only at state from before this cycle's results
      n = 0;
      if (mq.size() > 0 && mq[0].done) n = 1;
      if (n == 1 && mq.size() > 1 && mq[1].done) n = 2;
      for (int s = 0; s < 2; s++) begin
         e_we[s] = 1'b0;
         if (s < n) begin
            e_we[s] = has_result(mq[s].op);
            e_pa[s] = mq[s].pd;
            e_pd[s] = mq[s].data;
            e_fp[s] = mq[s].opd;
         end
      end
      // results: lowest port claims an index first; forwarding ignores validity
      for (int p = 0; p < 3; p++) begin
         e_ff[p] = rv[p];
         if (rv[p]) begin
            e_dr[p] = rdest[p];
            e_fd[p] = rdata[p];
            if (!won[rrob[p]]) begin
               won[rrob[p]] = 1'b1;
               for (int k = 0; k < mq.size(); k++) begin
                  if (mq[k].idx == int'(rrob[p])) begin
                     mq[k].done = 1'b1;
                     mq[k].data = rdata[p];
                  end
               end
            end
         end
      end
      repeat (n) void'(mq.pop_front());
      if (u_rob && cnt0 <= 14) begin
         mq.push_back('{idx: m_tail, pd: rob_p[0], op: rob_op[0], opd: o_rob_p[0], done: 1'b0, data: '0});
         mq.push_back('{idx: (m_tail + 1) % 16, pd: rob_p[1], op: rob_op[1], opd: o_rob_p[1], done: 1'b0, data: '0});
         m_tail = (m_tail + 2) % 16;
      end
      @(posedge clk);
      #1;
      check_all(tag);
      clear_inputs();
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      mq.delete();
      m_tail = 0;
      for (int p = 0; p < 3; p++) begin
         e_ff[p] = 1'b0; e_dr[p] = '0; e_fd[p] = '0;
      end
      for (int s = 0; s < 2; s++) begin
         e_we[s] = 1'b0; e_pa[s] = '0; e_pd[s] = '0; e_fp[s] = '0;
      end
      #2;
      check_all("rst_async");
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_all("rst_after");
   endtask

   // Complete every outstanding entry (up to three per cycle) until the ROB empties.
   task automatic drain(input string tag);
      for (int t = 0; t < 64 && mq.size() > 0; t++) begin
         int p;
         p = 0;
         foreach (mq[k]) begin
            if (!mq[k].done && p < 3) begin
               set_res(p, mq[k].idx, mq[k].pd, $urandom);
               p++;
            end
         end
         tick(tag);
      end
      check({tag, ":drained"}, rob_count, 0);
   endtask

   initial begin
      clear_inputs();
      @(posedge clk);
      #1;
      do_reset();

      // reset in the middle of activity
      for (int i = 0; i < 3; i++) begin
         set_alloc(6'(20 + i), T_ALU, 6'(30 + i), 6'(40 + i), T_ALU, 6'(50 + i));
         tick("mid_alloc");
      end
      set_res(0, 0, 6'd20, 32'h55);
      rst = 1'b1;
      #2;
      check("mid_rst_count", rob_count, 0);
      check("mid_rst_ready", alloc_ready, 1);
      do_reset();
      check("mid_rst_we", prf_we_1, 0);

      // basic allocate / complete / forward / retire
      set_alloc(6'd10, T_ALU, 6'd3, 6'd11, T_ALU, 6'd4);
      tick("basic_alloc");
      set_res(0, 0, 6'd10, 32'd7);
      set_res(1, 1, 6'd11, 32'd9);
      tick("basic_res");
      check("basic_fwd_flag_1", f_flag_1, 1);
      check("basic_fwd_dest_2", dest_r_2, 11);
      tick("basic_retire");
      check("basic_prf_data_1", prf_data_1, 7);
      check("basic_prf_data_2", prf_data_2, 9);
      check("basic_free_preg_2", free_preg_2, 4);
      check("basic_count", rob_count, 0);

      // out-of-order completion, in-order retirement (entries 2..5)
      set_alloc(6'd12, T_ALU, 6'd5, 6'd13, T_ALU, 6'd6);
      tick("ooo_alloc");
      set_alloc(6'd14, T_ALU, 6'd7, 6'd15, T_ALU, 6'd8);
      tick("ooo_alloc");
      set_res(0, 3, 6'd13, 32'h13);
      set_res(1, 4, 6'd14, 32'h14);
      set_res(2, 5, 6'd15, 32'h15);
      tick("ooo_res_late");
      tick("ooo_wait");
      check("ooo_no_retire", prf_we_1, 0);
      set_res(0, 2, 6'd12, 32'h12);
      tick("ooo_res_head");
      tick("ooo_retire_a");
      check("ooo_retire_a_addr", prf_addr_1, 12);
      tick("ooo_retire_b");
      check("ooo_retire_b_addr", prf_addr_2, 15);

      // fill to full, drop an allocation, then free two slots
      for (int i = 0; i < 8; i++) begin
         set_alloc(6'(2 * i), T_ALU, 6'(32 + 2 * i), 6'(2 * i + 1), T_ALU, 6'(33 + 2 * i));
         tick("full_alloc");
      end
      check("full_count", rob_count, 16);
      check("full_ready", alloc_ready, 0);
      set_alloc(6'd60, T_ALU, 6'd61, 6'd62, T_ALU, 6'd63);
      tick("full_drop");
      check("full_tail_held", alloc_idx_1, 6);
      set_res(0, 6, 6'd0, 32'hA0);
      set_res(1, 7, 6'd1, 32'hA1);
      tick("full_res");
      tick("full_retire");
      check("full_ready_again", alloc_ready, 1);
      drain("full_drain");

      // sustained alloc/retire so the pointers wrap several times
      for (int i = 0; i < 40; i++) begin
         int p;
         p = 0;
         foreach (mq[k]) begin
            if (!mq[k].done && p < 3) begin
               set_res(p, mq[k].idx, mq[k].pd, $urandom);
               p++;
            end
         end
         set_alloc(6'($urandom), T_ALU, 6'($urandom), 6'($urandom), T_ALU, 6'($urandom));
         tick("wrap");
      end
      drain("wrap_drain");

      // port collision and a result to an invalid entry
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_alloc(6'(2 * i + 1), T_ALU, 6'(2 * i + 20), 6'(2 * i + 2), T_ALU, 6'(2 * i + 21));
         tick("coll_alloc");
      end
      set_res(0, 5, 6'd6, 32'd1);
      set_res(2, 5, 6'd6, 32'd2);
      set_res(1, 9, 6'd33, 32'hAB);
      tick("coll_res");
      check("coll_fwd_invalid", f_flag_2, 1);
      check("coll_count", rob_count, 6);
      drain("coll_drain");

      // store at head: no PRF write, no free, but head advances
      set_alloc(6'd44, T_STORE, 6'd45, 6'd46, T_ALU, 6'd47);
      tick("store_alloc");
      set_res(0, m_tail - 2 < 0 ? m_tail + 14 : m_tail - 2, 6'd44, 32'h1);
      set_res(1, (m_tail + 15) % 16, 6'd46, 32'h2);
      tick("store_res");
      tick("store_retire");
      check("store_we_1", prf_we_1, 0);
      check("store_free_1", free_valid_1, 0);
      check("store_we_2", prf_we_2, 1);
      check("store_count", rob_count, 0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         u_rob = ($urandom_range(0, 99) < 55);
         for (int s = 0; s < 2; s++) begin
            int r;
            r = $urandom_range(0, 5);
            rob_op[s]  = (r == 0) ? T_STORE : (r == 1) ? T_BRANCH : 7'($urandom);
            rob_p[s]   = 6'($urandom);
            o_rob_p[s] = 6'($urandom);
         end
         for (int p = 0; p < 3; p++) begin
            if ($urandom_range(0, 99) < 60) begin
               if (mq.size() > 0 && $urandom_range(0, 9) < 8)
                  set_res(p, mq[$urandom_range(0, mq.size() - 1)].idx, 6'($urandom), $urandom);
               else
                  set_res(p, $urandom_range(0, 15), 6'($urandom), $urandom);
            end
         end
         tick("rand");
      end
      drain("rand_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
